// File: rtl/kernel_mem_arb_pkg.sv
// Shared definitions for the kernel on-chip memory arbiter.
//   RESP_OKAY / RESP_SLVERR : Avalon response codes returned with readdatavalid
//   DEPTH_DEFAULT           : number of valid RAM words (46080)
//   rd_tag_t                : per-read bookkeeping carried through the latency pipe
package kernel_mem_arb_pkg;

    localparam int         DEPTH_DEFAULT = 46080;
    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [1:0] RESP_SLVERR   = 2'b10;

    typedef struct packed {
        logic valid;   // slot carries an issued read
        logic owner;   // 0 = rq0, 1 = rq1
        logic err;     // address was out of range; return zero data + SLVERR
    } rd_tag_t;

endpackage

// File: rtl/kernel_mem_arb_rr2.sv
// Two-requester round-robin grant.
//   clk, reset : clock and synchronous active-high reset
//   req[1:0]   : request per port
//   grant_en   : when low no grant is issued (halt / reset)
//   grant[1:0] : one-hot combinational grant for the current cycle
// The port that did not win last time wins a conflict; reset makes rq0 the
// favourite for the first conflict.
module kernel_mem_arb_rr2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] grant
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        grant = 2'b00;
        if (grant_en) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end

        last_grant_d = last_grant_q;
        if (|grant) begin
            last_grant_d = grant[1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/kernel_onchip_memory_arbiter.sv
// Shares the single-port kernel on-chip RAM between the Nios data master (rq0)
// and the scan-data DMA writer (rq1). One access per cycle, round-robin on
// conflict, read data routed back to its owner RD_LAT+1 cycles after grant.
// Out-of-range accesses are accepted but never reach the RAM: writes are
// dropped with an rq_err_write pulse, reads return zero with SLVERR.
//   clk, reset            : clock, synchronous active-high reset
//   halt                  : blocks new grants; in-flight reads still return
//   rqN_*                 : Avalon-MM slave ports for requester N
//   rq_err_write          : pulse one cycle after an out-of-range write
//   mem_*                 : RAM interface (read latency RD_LAT)
module kernel_onchip_memory_arbiter
    import kernel_mem_arb_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                halt,

    input  logic [ADDR_W-1:0]   rq0_address,
    input  logic [DATA_W/8-1:0] rq0_byteenable,
    input  logic                rq0_read,
    input  logic                rq0_write,
    input  logic [DATA_W-1:0]   rq0_writedata,
    output logic                rq0_waitrequest,
    output logic [DATA_W-1:0]   rq0_readdata,
    output logic                rq0_readdatavalid,
    output logic [1:0]          rq0_response,

    input  logic [ADDR_W-1:0]   rq1_address,
    input  logic [DATA_W/8-1:0] rq1_byteenable,
    input  logic                rq1_read,
    input  logic                rq1_write,
    input  logic [DATA_W-1:0]   rq1_writedata,
    output logic                rq1_waitrequest,
    output logic [DATA_W-1:0]   rq1_readdata,
    output logic                rq1_readdatavalid,
    output logic [1:0]          rq1_response,

    output logic                rq_err_write,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_chipselect,
    output logic                mem_write,
    input  logic [DATA_W-1:0]   mem_readdata
);

    logic [1:0] grant;
    logic       any_grant;
    logic       sel;
    logic       mux_read;
    logic       mux_write;
    logic       in_range;

    kernel_mem_arb_rr2 u_rr2 (
        .clk      (clk),
        .reset    (reset),
        .req      ({rq1_read | rq1_write, rq0_read | rq0_write}),
        .grant_en (~halt & ~reset),
        .grant    (grant)
    );

    assign any_grant       = |grant;
    assign sel             = grant[1];
    assign rq0_waitrequest = ~grant[0];
    assign rq1_waitrequest = ~grant[1];

    // With no grant sel is 0, so the address/data lanes idle on rq0's values.
    assign mem_address    = sel ? rq1_address    : rq0_address;
    assign mem_byteenable = sel ? rq1_byteenable : rq0_byteenable;
    assign mem_writedata  = sel ? rq1_writedata  : rq0_writedata;
    assign mux_read       = sel ? rq1_read       : rq0_read;
    assign mux_write      = sel ? rq1_write      : rq0_write;

    assign in_range       = (32'(mem_address) < 32'(DEPTH));
    assign mem_chipselect = any_grant & in_range;
    assign mem_write      = mem_chipselect & mux_write;

    // Read tag pipeline: stage RD_LAT-1 lines up with mem_readdata.
    rd_tag_t pipe_q [RD_LAT];
    rd_tag_t pipe_d [RD_LAT];
    rd_tag_t tail;

    logic              err_write_q,  err_write_d;
    logic              rdv0_q,       rdv0_d;
    logic              rdv1_q,       rdv1_d;
    logic [DATA_W-1:0] rdata0_q,     rdata0_d;
    logic [DATA_W-1:0] rdata1_q,     rdata1_d;
    logic [1:0]        resp0_q,      resp0_d;
    logic [1:0]        resp1_q,      resp1_d;
    logic [DATA_W-1:0] ret_data;
    logic [1:0]        ret_resp;

    assign tail = pipe_q[RD_LAT-1];

    always_comb begin
        pipe_d[0].valid = any_grant & mux_read;
        pipe_d[0].owner = sel;
        pipe_d[0].err   = ~in_range;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        err_write_d = any_grant & mux_write & ~in_range;

        ret_data = tail.err ? '0 : mem_readdata;
        ret_resp = tail.err ? RESP_SLVERR : RESP_OKAY;

        rdv0_d   = tail.valid & ~tail.owner;
        rdv1_d   = tail.valid &  tail.owner;
        // Data/response hold their last value between returns.
        rdata0_d = rdv0_d ? ret_data : rdata0_q;
        rdata1_d = rdv1_d ? ret_data : rdata1_q;
        resp0_d  = rdv0_d ? ret_resp : resp0_q;
        resp1_d  = rdv1_d ? ret_resp : resp1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
            err_write_q <= 1'b0;
            rdv0_q      <= 1'b0;
            rdv1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            resp0_q     <= RESP_OKAY;
            resp1_q     <= RESP_OKAY;
        end else begin
            pipe_q      <= pipe_d;
            err_write_q <= err_write_d;
            rdv0_q      <= rdv0_d;
            rdv1_q      <= rdv1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            resp0_q     <= resp0_d;
            resp1_q     <= resp1_d;
        end
    end

    assign rq_err_write      = err_write_q;
    assign rq0_readdatavalid = rdv0_q;
    assign rq1_readdatavalid = rdv1_q;
    assign rq0_readdata      = rdata0_q;
    assign rq1_readdata      = rdata1_q;
    assign rq0_response      = resp0_q;
    assign rq1_response      = resp1_q;

endmodule

// File: tb/tb_kernel_onchip_memory_arbiter.sv
module tb_kernel_onchip_memory_arbiter;

    localparam int DEPTH = 46080;

    logic        clk = 1'b0;
    logic        reset, halt;
    logic [15:0] rq0_address, rq1_address;
    logic [3:0]  rq0_byteenable, rq1_byteenable;
    logic        rq0_read, rq0_write, rq1_read, rq1_write;
    logic [31:0] rq0_writedata, rq1_writedata;
    logic        rq0_waitrequest, rq1_waitrequest;
    logic [31:0] rq0_readdata, rq1_readdata;
    logic        rq0_readdatavalid, rq1_readdatavalid;
    logic [1:0]  rq0_response, rq1_response;
    logic        rq_err_write;
    logic [15:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic        mem_chipselect, mem_write;
    logic [31:0] mem_readdata;

    kernel_onchip_memory_arbiter dut (
        .clk(clk), .reset(reset), .halt(halt),
        .rq0_address(rq0_address), .rq0_byteenable(rq0_byteenable),
        .rq0_read(rq0_read), .rq0_write(rq0_write), .rq0_writedata(rq0_writedata),
        .rq0_waitrequest(rq0_waitrequest), .rq0_readdata(rq0_readdata),
        .rq0_readdatavalid(rq0_readdatavalid), .rq0_response(rq0_response),
        .rq1_address(rq1_address), .rq1_byteenable(rq1_byteenable),
        .rq1_read(rq1_read), .rq1_write(rq1_write), .rq1_writedata(rq1_writedata),
        .rq1_waitrequest(rq1_waitrequest), .rq1_readdata(rq1_readdata),
        .rq1_readdatavalid(rq1_readdatavalid), .rq1_response(rq1_response),
        .rq_err_write(rq_err_write),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit sb_en    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    // RAM environment: 1-cycle registered read, byte-lane writes.
    logic [31:0] ram     [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    always @(posedge clk) begin
        if (mem_chipselect && 32'(mem_address) < DEPTH) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    // Reference model: arbitration rule, expected-return queue, shadow memory.
    typedef struct {
        int          due;
        logic        owner;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_rd_t;

    exp_rd_t rdq[$];
    logic    lg_m    = 1'b1;
    logic    err_exp = 1'b0;

    always @(negedge clk) begin
        exp_rd_t     e;
        logic        r0, r1, gnt, win, wr, inr;
        logic [15:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
        if (sb_en) begin
            assert (!(rq0_read && rq0_write)) else $error("rq0 read and write together");
            assert (!(rq1_read && rq1_write)) else $error("rq1 read and write together");

            if (rdq.size() != 0 && rdq[0].due == cyc) begin
                e = rdq.pop_front();
                chk("rdv_route", {30'b0, rq1_readdatavalid, rq0_readdatavalid}, e.owner ? 32'd2 : 32'd1);
                chk("rdata", e.owner ? rq1_readdata : rq0_readdata, e.data);
                chk("resp", {30'b0, e.owner ? rq1_response : rq0_response}, {30'b0, e.resp});
            end else begin
                chk("rdv_idle", {30'b0, rq1_readdatavalid, rq0_readdatavalid}, 32'd0);
            end
            chk("err_write", {31'b0, rq_err_write}, {31'b0, err_exp});

            r0  = rq0_read | rq0_write;
            r1  = rq1_read | rq1_write;
            gnt = !reset && !halt && (r0 || r1);
            win = (r0 && r1) ? ~lg_m : r1 && !r0;
            a   = win ? rq1_address : rq0_address;
            wr  = win ? rq1_write : rq0_write;
            wd  = win ? rq1_writedata : rq0_writedata;
            be  = win ? rq1_byteenable : rq0_byteenable;
            inr = (32'(a) < DEPTH);

            chk("wait0", {31'b0, rq0_waitrequest}, {31'b0, !(gnt && !win)});
            chk("wait1", {31'b0, rq1_waitrequest}, {31'b0, !(gnt && win)});
            chk("mem_cs", {31'b0, mem_chipselect}, {31'b0, gnt && inr});
            chk("mem_we", {31'b0, mem_write}, {31'b0, gnt && inr && wr});
            if (gnt && inr) chk("mem_addr", {16'b0, mem_address}, {16'b0, a});

            if (reset) begin
                rdq.delete();
                err_exp = 1'b0;
                lg_m    = 1'b1;
            end else begin
                err_exp = gnt && wr && !inr;
                if (gnt) begin
                    lg_m = win;
                    if (!wr) begin
                        e.due   = cyc + 2;
                        e.owner = win;
                        e.data  = inr ? ref_mem[a] : 32'h0;
                        e.resp  = inr ? 2'b00 : 2'b10;
                        rdq.push_back(e);
                    end else if (inr) begin
                        for (int b = 0; b < 4; b++)
                            if (be[b]) ref_mem[a][b*8 +: 8] = wd[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Stimulus helpers: called at posedge+1.
    task automatic drive(input int p, input bit wr, input logic [15:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        if (p == 0) begin
            rq0_address = a; rq0_read = !wr; rq0_write = wr; rq0_writedata = wd; rq0_byteenable = be;
        end else begin
            rq1_address = a; rq1_read = !wr; rq1_write = wr; rq1_writedata = wd; rq1_byteenable = be;
        end
    endtask

    task automatic idle(input int p);
        if (p == 0) begin rq0_read = 0; rq0_write = 0; end
        else        begin rq1_read = 0; rq1_write = 0; end
    endtask

    task automatic next_cyc();
        @(posedge clk); #1;
    endtask

    typedef struct {
        int          p;
        bit          wr;
        logic [15:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        bit          exp_err;
    } vec_t;

    task automatic do_txn(input vec_t v);
        bit got = 0;
        bit seen = 0;
        int gc = 0;
        drive(v.p, v.wr, v.a, v.wd, v.be);
        for (int k = 0; k < 20 && !got; k++) begin
            #2;
            if (((v.p == 0) ? rq0_waitrequest : rq1_waitrequest) == 1'b0) begin
                got = 1; gc = cyc;
            end
            next_cyc();
        end
        idle(v.p);
        chk("txn_granted", {31'b0, got}, 32'd1);
        if (v.wr) begin
            #2;
            chk("txn_err_write", {31'b0, rq_err_write}, {31'b0, v.exp_err});
            next_cyc();
        end else begin
            for (int k = 0; k < 10 && !seen; k++) begin
                #2;
                if ((v.p == 0) ? rq0_readdatavalid : rq1_readdatavalid) begin
                    seen = 1;
                    chk("txn_latency", cyc - gc, 32'd2);
                    chk("txn_rdata", (v.p == 0) ? rq0_readdata : rq1_readdata, v.exp_d);
                    chk("txn_resp", {30'b0, (v.p == 0) ? rq0_response : rq1_response}, {30'b0, v.exp_r});
                end
                next_cyc();
            end
            chk("txn_rdv_seen", {31'b0, seen}, 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    vec_t vecs[11];

    initial begin
        int got;
        bit seen;
        bit busy[2];

        vecs[0]  = '{0, 0, 16'h0010, 32'h0,        4'hF, 32'hA5A5_0010, 2'b00, 0};
        vecs[1]  = '{1, 1, 16'h0100, 32'hFFFF_FFFF, 4'hF, 32'h0,         2'b00, 0};
        vecs[2]  = '{1, 1, 16'h0100, 32'h1122_3344, 4'h5, 32'h0,         2'b00, 0};
        vecs[3]  = '{0, 0, 16'h0100, 32'h0,        4'hF, 32'hFF22_FF44, 2'b00, 0};
        vecs[4]  = '{0, 0, 16'hB400, 32'h0,        4'hF, 32'h0,         2'b10, 0};
        vecs[5]  = '{1, 1, 16'hFFFF, 32'h1234_5678, 4'hF, 32'h0,         2'b00, 1};
        vecs[6]  = '{1, 0, 16'hFFFF, 32'h0,        4'hF, 32'h0,         2'b10, 0};
        vecs[7]  = '{1, 0, 16'hB3FF, 32'h0,        4'hF, 32'hA5A5_B3FF, 2'b00, 0};
        vecs[8]  = '{0, 1, 16'hB3FF, 32'hDEAD_BEEF, 4'hA, 32'h0,         2'b00, 0};
        vecs[9]  = '{0, 0, 16'hB3FF, 32'h0,        4'hF, 32'hDEA5_BEFF, 2'b00, 0};
        vecs[10] = '{1, 0, 16'h4BFF, 32'h0,        4'hF, 32'hA5A5_4BFF, 2'b00, 0};

        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = 32'hA5A5_0000 | 32'(i);
            ref_mem[i] = 32'hA5A5_0000 | 32'(i);
        end
        mem_readdata = 32'h0;
        reset = 1; halt = 0;
        rq0_address = 0; rq0_byteenable = 4'hF; rq0_read = 0; rq0_write = 0; rq0_writedata = 0;
        rq1_address = 0; rq1_byteenable = 4'hF; rq1_read = 0; rq1_write = 0; rq1_writedata = 0;

        // Reset state, with both ports requesting.
        repeat (2) @(posedge clk);
        #1;
        sb_en = 1;
        drive(0, 0, 16'h0001, 0, 4'hF);
        drive(1, 0, 16'h0002, 0, 4'hF);
        #2;
        chk("rst_wait0", {31'b0, rq0_waitrequest}, 32'd1);
        chk("rst_wait1", {31'b0, rq1_waitrequest}, 32'd1);
        chk("rst_cs", {31'b0, mem_chipselect}, 32'd0);
        chk("rst_rdv", {30'b0, rq1_readdatavalid, rq0_readdatavalid}, 32'd0);
        chk("rst_rdata0", rq0_readdata, 32'd0);
        chk("rst_resp", {28'b0, rq1_response, rq0_response}, 32'd0);
        chk("rst_err", {31'b0, rq_err_write}, 32'd0);
        next_cyc();
        reset = 0;

        // Conflict: continuous reads from both ports alternate rq0, rq1, rq0, rq1.
        drive(0, 0, 16'h0020, 0, 4'hF);
        drive(1, 0, 16'h0021, 0, 4'hF);
        for (int i = 0; i < 4; i++) begin
            #2;
            got = !rq0_waitrequest ? 0 : (!rq1_waitrequest ? 1 : 2);
            chk("conflict_order", 32'(got), 32'(i % 2));
            next_cyc();
            if (got == 0) rq0_address = rq0_address + 16'd2;
            if (got == 1) rq1_address = rq1_address + 16'd2;
        end
        idle(0); idle(1);
        repeat (3) next_cyc();

        for (int i = 0; i < 11; i++) do_txn(vecs[i]);

        // halt with a read in flight.
        drive(0, 0, 16'h0030, 0, 4'hF);
        #2;
        chk("halt_pre_grant", {31'b0, rq0_waitrequest}, 32'd0);
        next_cyc();
        idle(0);
        halt = 1;
        drive(1, 0, 16'h0031, 0, 4'hF);
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("halt_wait1", {31'b0, rq1_waitrequest}, 32'd1);
            if (rq0_readdatavalid) seen = 1;
            next_cyc();
        end
        chk("halt_inflight_return", {31'b0, seen}, 32'd1);
        halt = 0;
        #2;
        chk("halt_release_grant", {31'b0, rq1_waitrequest}, 32'd0);
        next_cyc();
        idle(1);
        repeat (3) next_cyc();

        // Make rq1 the favourite so the post-reset conflict proves reset restored rq0.
        drive(0, 0, 16'h0005, 0, 4'hF);
        next_cyc();
        idle(0);
        repeat (3) next_cyc();

        // Reset one cycle after a read grant: the read never returns.
        drive(0, 0, 16'h0040, 0, 4'hF);
        #2;
        chk("rstmid_grant", {31'b0, rq0_waitrequest}, 32'd0);
        next_cyc();
        idle(0);
        reset = 1;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            #2;
            if (k >= 1 && (rq0_readdatavalid || rq1_readdatavalid)) seen = 1;
            next_cyc();
            if (k == 1) reset = 0;
        end
        chk("rstmid_no_rdv", {31'b0, seen}, 32'd0);
        chk("rstmid_rdata0", rq0_readdata, 32'd0);
        drive(0, 0, 16'h0050, 0, 4'hF);
        drive(1, 0, 16'h0051, 0, 4'hF);
        #2;
        chk("rstmid_first_conflict", {30'b0, rq1_waitrequest, rq0_waitrequest}, 32'd2);
        next_cyc();
        idle(0);
        #2;
        chk("rstmid_second_grant", {31'b0, rq1_waitrequest}, 32'd0);
        next_cyc();
        idle(1);
        repeat (3) next_cyc();

        // Randomized Avalon-compliant traffic; the negedge model checks every cycle.
        busy[0] = 0; busy[1] = 0;
        for (int n = 0; n < 500; n++) begin
            halt = ($urandom % 8 == 0);
            for (int p = 0; p < 2; p++) begin
                if (!busy[p]) begin
                    if ($urandom % 3 != 0) begin
                        int sel;
                        logic [15:0] a;
                        sel = $urandom % 10;
                        if (sel == 0)      a = 16'(DEPTH + ($urandom % (65536 - DEPTH)));
                        else if (sel == 1) a = 16'(DEPTH - 1);
                        else               a = 16'($urandom % 64);
                        busy[p] = 1;
                        drive(p, $urandom % 2, a, $urandom, 4'($urandom % 16));
                    end else begin
                        idle(p);
                    end
                end
            end
            #2;
            if (busy[0] && !rq0_waitrequest) busy[0] = 0;
            if (busy[1] && !rq1_waitrequest) busy[1] = 0;
            next_cyc();
        end
        halt = 0;
        for (int k = 0; k < 20 && (busy[0] || busy[1]); k++) begin
            if (!busy[0]) idle(0);
            if (!busy[1]) idle(1);
            #2;
            if (busy[0] && !rq0_waitrequest) busy[0] = 0;
            if (busy[1] && !rq1_waitrequest) busy[1] = 0;
            next_cyc();
        end
        idle(0); idle(1);
        repeat (6) next_cyc();
        chk("drain_all_returned", 32'(rdq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
